// File: rtl/maindec_fsm.sv
// ---------------------------------------------------------------------------
// maindec_fsm -- multicycle main controller for the 32-bit MIPS-style CPU.
//
// Steps each instruction through FETCH / DECODE / execute / memory /
// writeback states. It stalls in FETCH, MEMRD and MEMWR until the memory
// signals completion on mem_ready. All datapath controls are Moore outputs
// decoded from the registered state. The only exception is FETCH, where
// irwrite/pcwrite follow mem_ready.
//
// Ports
//   clk        in   1       single clock, state updates on rising edge
//   reset_n    in   1       asynchronous active-low reset (state -> FETCH)
//   op         in   OPW     opcode from the instruction register
//   mem_ready  in   1       memory access completes this cycle
//   pcwrite, branch, irwrite, memwrite, regwrite
//              out  1       write strobes (forced 0 while reset is held)
//   iord, regdst, memtoreg, alusrca
//              out  1       mux selects
//   alusrcb    out  2       00 reg, 01 const 4, 10 signext imm, 11 imm<<2
//   pcsrc      out  2       00 ALU, 01 ALUOut, 10 jump target
//   aluop      out  ALUOPW  ADD=0, SUB=1, FUNCT=2
//   state      out  4       current state encoding (debug)
//   illegal    out  1       high while parked in the ILLEGAL state
//
// Build option
//   MAINDEC_FSM_TRAP_EN  defined:   an unknown opcode traps in ILLEGAL until
//                                   reset.
//                        undefined: an unknown opcode runs as a 2-cycle NOP.
//                                   illegal is tied 0.
// ---------------------------------------------------------------------------
module maindec_fsm #(
    parameter int             OPW      = 6,
    parameter int             ALUOPW   = 4,
    parameter logic [OPW-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OPW-1:0] OP_LW    = 6'b100011,
    parameter logic [OPW-1:0] OP_SW    = 6'b101011,
    parameter logic [OPW-1:0] OP_BEQ   = 6'b000100,
    parameter logic [OPW-1:0] OP_ADDI  = 6'b001000,
    parameter logic [OPW-1:0] OP_J     = 6'b000010
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [OPW-1:0]    op,
    input  logic              mem_ready,
    output logic              pcwrite,
    output logic              branch,
    output logic              irwrite,
    output logic              memwrite,
    output logic              regwrite,
    output logic              iord,
    output logic              regdst,
    output logic              memtoreg,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic [ALUOPW-1:0] aluop,
    output logic [3:0]        state,
    output logic              illegal
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
`ifdef MAINDEC_FSM_TRAP_EN
    localparam logic [3:0] S_ILLEGAL = 4'd12;
`endif

    localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] ALU_FUNCT = ALUOPW'(2);

    logic [3:0] state_q, state_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples its pre-edge inputs, regardless of the order in which
    // the blocks are evaluated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. op is looked at only in DECODE/MEMADR, and
    // mem_ready only in FETCH/MEMRD/MEMWR.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in a combinational block is given a
        // default first. Otherwise any path that skips an assignment
        // infers a latch. This default also sends the unused encodings
        // back to FETCH.
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    state_d = S_EXECUTE;
                end else if (op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (op == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else if (op == OP_J) begin
                    state_d = S_JUMP;
                end else begin
`ifdef MAINDEC_FSM_TRAP_EN
                    state_d = S_ILLEGAL;
`else
                    state_d = S_FETCH;   // unknown opcode: 2-cycle NOP
`endif
                end
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
`ifdef MAINDEC_FSM_TRAP_EN
            S_ILLEGAL: state_d = S_ILLEGAL;   // parked until reset
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALU_ADD;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE:  alusrcb = 2'b11;      // branch target precompute
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;             // held across wait cycles
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MAINDEC_FSM_TRAP_EN
            S_ILLEGAL: illegal = 1'b1;
`endif
            default: ;
        endcase

        // FETCH's strobes follow mem_ready. They must not fire while reset
        // is held, so gate all write strobes directly on reset_n.
        if (!reset_n) begin
            pcwrite  = 1'b0;
            branch   = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign state = state_q;

endmodule
